// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, control field indices and default widths for pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 6;

    localparam int CTRL_MEMWR       = 0;
    localparam int CTRL_MEMTOREG_LO = 1;
    localparam int CTRL_MEMTOREG_HI = 2;
    localparam int CTRL_REGWR       = 3;
    localparam int CTRL_PCSRC_LO    = 4;
    localparam int CTRL_PCSRC_HI    = 5;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - 32-bit event counter that sticks at all-ones
module pipe_sat_cnt
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {PERF_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - 2-entry skid pipeline register with flush; STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    pipe_state_t       state, state_next;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              push, pop;
    logic              load_main_in, load_main_skid, load_skid_in;

    // Both handshake outputs decode the state register only, so in_ready never sees out_ready.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state_next   = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_next   = ST_TWO;
                        load_skid_in = 1'b1;
                    end else if (pop && !push) begin
                        state_next = ST_EMPTY;
                    end else if (push && pop) begin
                        load_main_in = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_next     = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Flush turns stored entries into bubbles: control cleared, payload left as is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

`ifdef STAGE_PERF_EN
    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid),
        .cnt   (bubble_cnt)
    );
`endif

endmodule
